// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between instruction fetch and load/store.
// Build option MEM_ARB_RR_EN: round-robin under contention (default: data port always wins).
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                grant_d_reg;  // 1 = data port owns the transaction in flight
  logic                we_reg;
  logic [BE_W-1:0]     be_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   if_rdata_reg;
  logic [DATA_W-1:0]   d_rdata_reg;
  logic                pick_d;
  logic                latch;
  logic                capture;

`ifdef MEM_ARB_RR_EN
  logic last_d_reg;

  // Under contention the port that did not win last time gets the grant.
  assign pick_d = d_req & (~if_req | ~last_d_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_reg <= 1'b0;
    end else if (latch) begin
      last_d_reg <= pick_d;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch      = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (if_req | d_req) begin
          latch      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (we_reg) begin
          state_next = RESP;
        end else begin
          cnt_next   = CNT_W'(MEM_LAT - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      grant_d_reg  <= 1'b0;
      we_reg       <= 1'b0;
      be_reg       <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (latch) begin
        grant_d_reg <= pick_d;
        we_reg      <= pick_d & d_we;
        be_reg      <= (pick_d & d_we) ? d_be : '1;
        addr_reg    <= pick_d ? d_addr : if_addr;
        wdata_reg   <= pick_d ? d_wdata : '0;
      end
      if (capture) begin
        if (grant_d_reg) begin
          d_rdata_reg <= mem_rdata;
        end else begin
          if_rdata_reg <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_reg == ISSUE);
  assign mem_we    = mem_en & we_reg;
  assign mem_be    = be_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

  assign if_valid = (state_reg == RESP) & ~grant_d_reg;
  assign d_valid  = (state_reg == RESP) &  grant_d_reg;
  assign if_rdata = if_rdata_reg;
  assign d_rdata  = d_rdata_reg;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory macro model plus a transaction-level reference of
// grant order, latency and memory contents; follows MEM_ARB_RR_EN when defined.
module tb_mem_arbiter;
  localparam int MEM_LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_valid, d_stall;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 64) return 32'h00500093;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory macro: byte-enabled writes at mem_en, read data appears MEM_LAT cycles later.
  logic [31:0] mem_arr [256];
  logic [31:0] pipe_d  [MEM_LAT];
  logic        pipe_v  [MEM_LAT];
  bit          env_ready = 1'b0;

  always @(posedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
      for (int i = 0; i < MEM_LAT; i++) pipe_v[i] <= 1'b0;
      env_ready <= 1'b1;
    end else begin
      pipe_v[0] <= mem_en & ~mem_we;
      pipe_d[0] <= mem_arr[mem_addr[9:2]];
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      if (mem_en && mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  assign mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hDEADBEEF;

  // Reference state
  logic [31:0] ref_mem [256];
  logic [31:0] m_if_rdata, m_d_rdata;
  bit          m_last_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One contention round: drive the requests in an IDLE cycle T, then check every
  // following cycle against the spec timeline (read valid at T+2+MEM_LAT, write at T+2,
  // loser starts in the IDLE cycle after the winner's valid).
  task automatic run_case(input bit fr, input logic [31:0] fa,
                          input bit dr, input bit dwe, input logic [3:0] dbe,
                          input logic [31:0] da, input logic [31:0] dwd, input int drop_k);
    bit d_first;
    int sf, vf, sd, vd, total, lf, ld;
    bit exp_en, exp_ifv, exp_dv;
    d_first = dr && (!fr || !RR || !m_last_d);
    lf = 2 + MEM_LAT;
    ld = dwe ? 2 : 2 + MEM_LAT;
    if (d_first) begin
      sd = 0; vd = ld; sf = vd + 1; vf = sf + lf;
    end else begin
      sf = 0; vf = lf; sd = vf + 1; vd = sd + ld;
    end
    total = ((fr && vf > vd) || !dr) ? vf + 1 : vd + 1;
    if (fr && dr) m_last_d = !d_first;
    else          m_last_d = dr;
    if_req = fr; if_addr = fa;
    d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      exp_en = (fr && k == sf + 1) || (dr && k == sd + 1);
      chk("mem_en", mem_en, exp_en);
      if (fr && k == sf + 1) begin
        chk("if_mem_addr", mem_addr, fa);
        chk("if_mem_we", mem_we, 0);
        chk("if_mem_be", mem_be, 4'hF);
      end
      if (dr && k == sd + 1) begin
        chk("d_mem_addr", mem_addr, da);
        chk("d_mem_we", mem_we, dwe);
        chk("d_mem_be", mem_be, dwe ? dbe : 4'hF);
        if (dwe) begin
          chk("d_mem_wdata", mem_wdata, dwd);
          for (int b = 0; b < 4; b++)
            if (dbe[b]) ref_mem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
        end
      end
      exp_ifv = fr && k == vf;
      exp_dv  = dr && k == vd;
      if (exp_ifv) m_if_rdata = ref_mem[fa[9:2]];
      if (exp_dv && !dwe) m_d_rdata = ref_mem[da[9:2]];
      chk("if_valid", if_valid, exp_ifv);
      chk("d_valid", d_valid, exp_dv);
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata", d_rdata, m_d_rdata);
      chk("if_stall", if_stall, if_req & ~exp_ifv);
      chk("d_stall", d_stall, d_req & ~exp_dv);
      $display("cyc %0d: en=%b ifv=%b dv=%b addr=%h", k, mem_en, if_valid, d_valid, mem_addr);
      // Dropped ports scramble their inputs: the latched request must be unaffected.
      if (exp_ifv) begin
        if_req = 1'b0; if_addr = $urandom;
      end
      if (exp_dv || (drop_k == k && d_first)) begin
        d_req = 1'b0; d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
      end
    end
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, "_mem_en"}, mem_en, 0);
    chk({ph, "_mem_we"}, mem_we, 0);
    chk({ph, "_mem_be"}, mem_be, 0);
    chk({ph, "_mem_addr"}, mem_addr, 0);
    chk({ph, "_mem_wdata"}, mem_wdata, 0);
    chk({ph, "_if_rdata"}, if_rdata, 0);
    chk({ph, "_d_rdata"}, d_rdata, 0);
    chk({ph, "_if_valid"}, if_valid, 0);
    chk({ph, "_d_valid"}, d_valid, 0);
    chk({ph, "_if_stall"}, if_stall, 0);
    chk({ph, "_d_stall"}, d_stall, 0);
  endtask

  initial begin
    bit fr, dr, dwe;
    logic [31:0] fa, da, dwd;
    logic [3:0]  dbe;
    int drop_k;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    m_if_rdata = '0; m_d_rdata = '0; m_last_d = 1'b0;
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Directed: fetch only, store then load, contention, repeated contention
    run_case(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0);
    chk("fetch_word", if_rdata, 32'h00500093);
    run_case(0, 32'h0, 1, 1, 4'b0001, 32'h204, 32'h000000AB, 0);
    run_case(0, 32'h0, 1, 0, 4'h0, 32'h204, 32'h0, 0);
    chk("load_204_lo", d_rdata[7:0], 8'hAB);
    run_case(1, 32'h104, 1, 0, 4'h0, 32'h300, 32'h0, 0);
    for (int r = 0; r < 3; r++)
      run_case(1, 32'h108 + 32'(4 * r), 1, 0, 4'h0, 32'h304 + 32'(4 * r), 32'h0, 0);

    // Reset asserted while a load waits on memory
    if_req = 0; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h300;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1; d_req = 1'b0;
    #1 chk_all_zero("async_rst");
    m_if_rdata = '0; m_d_rdata = '0; m_last_d = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_mem_en", mem_en, 0);
      chk("post_rst_d_valid", d_valid, 0);
    end
    run_case(0, 32'h0, 1, 0, 4'h0, 32'h300, 32'h0, 0);

    // Load whose requester leaves during WAIT, with a fetch pending
    run_case(1, 32'h110, 1, 0, 4'h0, 32'h208, 32'h0, 2);
    run_case(1, 32'h114, 1, 0, 4'h0, 32'h20C, 32'h0, 2);

    // Randomized mix over a small shared window so fetches observe stores
    for (int n = 0; n < 40; n++) begin
      fr  = ($urandom_range(0, 1) == 1);
      dr  = ($urandom_range(0, 1) == 1);
      if (!fr && !dr) dr = 1'b1;
      fa  = 32'h200 + ($urandom_range(0, 15) << 2);
      da  = 32'h200 + ($urandom_range(0, 15) << 2);
      dwe = ($urandom_range(0, 1) == 1);
      dbe = 4'($urandom_range(1, 15));
      dwd = $urandom;
      drop_k = (dr && !dwe && $urandom_range(0, 3) == 0) ? 2 : 0;
      run_case(fr, fa, dr, dwe, dbe, da, dwd, drop_k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the instruction-fetch port and the load/store data port of the RISC-V core.
- Sequences each access through a small FSM, returns read data to the winning requester, and provides stall signals to the core.
- Sits between fetch/LSU logic and the memory macro.
- The data port wins by default, because a load/store belongs to an older instruction than the pending fetch.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_valid (combinational).
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  byte enables for stores.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle completion pulse for data.
- d_stall  out  1  d_req & ~d_valid (combinational).
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_be  out  DATA_W/8  memory byte enables; forced to all-ones on reads.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after the mem_en cycle.

Behaviour:
- Reset (async): state=IDLE, wait counter=0, last_grant=FETCH. All outputs are 0 immediately, including mem_en, both valids and both rdata registers.
- Registered request latch: grant, we, be, addr and wdata are captured on leaving IDLE. mem_* are driven from these registers only.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a winner (data over fetch if both), latch its request, go to ISSUE.
- ISSUE (1 cycle): mem_en=1.
  - Write: go to RESP.
  - Read: load counter=MEM_LAT-1, go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture mem_rdata into the granted rdata register and go to RESP.
- RESP (1 cycle): the granted valid is 1, then go to IDLE.
  - Store valid carries no data; d_rdata holds its previous value.
- Latency, from the request cycle T in IDLE:
  - Read: mem_en at T+1; valid at T+2+MEM_LAT.
  - Write: mem_en at T+1; valid at T+2.
- Back-to-back: at least one IDLE bubble between transactions, so a requester can drop or change its request after valid.
- rdata registers hold their value until the next read for that port.
- Requester drops req mid-transaction: the transaction still completes and the valid pulse still fires; the core ignores it.
- Request inputs are ignored outside IDLE.
- if_valid and d_valid are never high in the same cycle.
- mem_en is never high for more than one consecutive cycle.
- Reset mid-transaction: the transaction is aborted, no valid is produced, and no further mem_en is issued.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are pending in IDLE, the port not in last_grant wins. last_grant updates on every grant and resets to FETCH, so the first contention goes to data.
- Undefined: fixed priority, data always wins. last_grant logic is removed.
- Single-requester behaviour is identical in both builds.

Test Plan (MEM_LAT=2):
- Fetch only, if_addr=0x100, mem word 0x00500093 -> mem_en at T+1 with mem_addr=0x100; if_valid and if_rdata=0x00500093 at T+4; if_stall high T..T+3.
- Store d_we=1, d_addr=0x204, d_be=4'b0001, d_wdata=0xAB -> mem_en/mem_we at T+1 with mem_be=0001; d_valid at T+2; a subsequent load from 0x204 returns 0x000000AB in the low byte.
- Simultaneous if_req and d_req (load 0x300) -> data granted first, d_valid at T+4; fetch mem_en at T+6, if_valid at T+9.
- Repeat contention 3 times with MEM_ARB_RR_EN defined -> grants D, F, D, F alternate; undefined -> all data requests served before fetch.
- Assert rst during WAIT of a load -> all outputs 0 asynchronously, no d_valid; a request after rst release completes normally.
- Load with d_req dropped in WAIT -> d_valid still pulses at T+4; next IDLE grants a pending fetch.
